// File: rtl/fifo_uart_tx_if.sv
// FIFO read port seen by the UART transmitter: head word, empty flag and pop strobe.
// The transmitter is the master (it issues pops); the FIFO is the slave.
interface fifo_uart_tx_if #(
  parameter int WORD_LENGTH = 8
);
  logic [WORD_LENGTH-1:0] fifo_data;
  logic                   fifo_empty;
  logic                   fifo_read_en;

  modport master (input fifo_data, input fifo_empty, output fifo_read_en);
  modport slave  (output fifo_data, output fifo_empty, input fifo_read_en);
endinterface

// File: rtl/fifo_uart_tx.sv
// UART transmitter fed from a FIFO read port: start bit, data LSB first, optional even parity, one stop bit.
// Define FIFO_UART_TX_PARITY_EN to compile in the parity bit (frame becomes WORD_LENGTH+3 bits).
module fifo_uart_tx #(
  parameter int WORD_LENGTH  = 8,
  parameter int CLKS_PER_BIT = 868
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           tx_enable,
  fifo_uart_tx_if.master fifo,
  output logic           tx,
  output logic           busy
);
  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BIT_W  = $clog2(WORD_LENGTH + 1);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(WORD_LENGTH - 1);

`ifdef FIFO_UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t                 state_q, state_d;
  logic [BAUD_W-1:0]      baud_q, baud_d;
  logic [BIT_W-1:0]       bit_q, bit_d;
  logic [WORD_LENGTH-1:0] shift_q, shift_d;
  logic                   tx_d;
  logic                   baud_end;
  logic                   pop;
`ifdef FIFO_UART_TX_PARITY_EN
  logic                   parity_q, parity_d;
`endif

  assign baud_end = (baud_q == BAUD_LAST);

  // A pop may start a frame from IDLE or chain onto the last stop-bit cycle; reset suppresses it.
  assign pop = !reset && tx_enable && !fifo.fifo_empty &&
               ((state_q == IDLE) || ((state_q == STOP) && baud_end));
  assign fifo.fifo_read_en = pop;

  // Busy must already be high in the pop cycle, before the registered state leaves IDLE.
  assign busy = (state_q != IDLE) || pop;

  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    bit_d    = bit_q;
    tx_d     = tx;
    baud_d   = ((state_q == IDLE) || baud_end) ? '0 : baud_q + 1'b1;
`ifdef FIFO_UART_TX_PARITY_EN
    parity_d = parity_q;
`endif
    unique case (state_q)
      IDLE, STOP: begin
        if (pop) begin
          state_d  = START;
          shift_d  = fifo.fifo_data;
          tx_d     = 1'b0;
          baud_d   = '0;
`ifdef FIFO_UART_TX_PARITY_EN
          parity_d = ^fifo.fifo_data;
`endif
        end else if ((state_q == STOP) && baud_end) begin
          state_d = IDLE;
          tx_d    = 1'b1;
        end
      end
      START: begin
        if (baud_end) begin
          state_d = DATA;
          bit_d   = '0;
          tx_d    = shift_q[0];
        end
      end
      DATA: begin
        if (baud_end) begin
          shift_d = shift_q >> 1;
          bit_d   = bit_q + 1'b1;
          if (bit_q == BIT_LAST) begin
`ifdef FIFO_UART_TX_PARITY_EN
            state_d = PARITY;
            tx_d    = parity_q;
`else
            state_d = STOP;
            tx_d    = 1'b1;
`endif
          end else begin
            tx_d = shift_d[0];
          end
        end
      end
`ifdef FIFO_UART_TX_PARITY_EN
      PARITY: begin
        if (baud_end) begin
          state_d = STOP;
          tx_d    = 1'b1;
        end
      end
`endif
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      baud_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      tx       <= 1'b1;
`ifdef FIFO_UART_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      tx       <= tx_d;
`ifdef FIFO_UART_TX_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end
endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed + randomized bench for fifo_uart_tx with a FIFO model and a per-cycle expected-waveform queue.
module tb_fifo_uart_tx;
  localparam int WL  = 8;
  localparam int CPB = 4;
`ifdef FIFO_UART_TX_PARITY_EN
  localparam int FRAME_BITS = WL + 3;
`else
  localparam int FRAME_BITS = WL + 2;
`endif
  localparam int FRAME_CYC = FRAME_BITS * CPB;

  logic clk;
  logic reset;
  logic tx_enable;
  logic tx;
  logic busy;

  fifo_uart_tx_if #(.WORD_LENGTH(WL)) bus ();

  fifo_uart_tx #(.WORD_LENGTH(WL), .CLKS_PER_BIT(CPB)) dut (
    .clk       (clk),
    .reset     (reset),
    .tx_enable (tx_enable),
    .fifo      (bus),
    .tx        (tx),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [WL-1:0] fifo_q[$];
  logic          exp_q[$];
  int            pops[$];
  int            n_assert = 0;
  int            n_fail   = 0;
  int            cyc      = 0;
  int            pop_cnt  = 0;
  int            busy_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_assert++;
    assert (got === want) else begin
      n_fail++;
      $error("FAIL %s cyc=%0d got=%0h want=%0h", tag, cyc, got, want);
    end
  endtask

  task automatic drive_fifo();
    bus.fifo_empty = (fifo_q.size() == 0);
    bus.fifo_data  = (fifo_q.size() != 0) ? fifo_q[0] : '0;
  endtask

  task automatic push(input logic [WL-1:0] w);
    fifo_q.push_back(w);
    drive_fifo();
  endtask

  // Expected line waveform for one frame, one entry per clock.
  task automatic push_frame(input logic [WL-1:0] w);
    repeat (CPB) exp_q.push_back(1'b0);
    for (int i = 0; i < WL; i++) repeat (CPB) exp_q.push_back(w[i]);
`ifdef FIFO_UART_TX_PARITY_EN
    repeat (CPB) exp_q.push_back(^w);
`endif
    repeat (CPB) exp_q.push_back(1'b1);
  endtask

  // One clock: check outputs against the model, then let the FIFO respond to the pop.
  task automatic cycle();
    logic consumed, exp_tx, exp_pop, exp_busy, popped;
    #1;
    consumed = (exp_q.size() > 0);
    exp_tx   = consumed ? exp_q.pop_front() : 1'b1;
    exp_pop  = !reset && tx_enable && (fifo_q.size() > 0) && (exp_q.size() == 0);
    exp_busy = consumed || exp_pop;
    chk("tx", 32'(tx), 32'(exp_tx));
    chk("busy", 32'(busy), 32'(exp_busy));
    chk("read_en", 32'(bus.fifo_read_en), 32'(exp_pop));
    popped = bus.fifo_read_en;
    if (popped) begin
      pops.push_back(cyc);
      pop_cnt++;
    end
    if (busy) busy_cnt++;
    if (reset) exp_q.delete();
    else if (exp_pop) push_frame(fifo_q[0]);
    @(posedge clk);
    #1;
    if (popped && fifo_q.size() > 0) begin
      void'(fifo_q.pop_front());
      drive_fifo();
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    reset     = 1'b1;
    tx_enable = 1'b0;
    drive_fifo();
    @(negedge clk);

    // Reset idle
    run(3);
    reset = 1'b0;
    tx_enable = 1'b1;
    run(2);

    // Single frame 0xA5
    pop_cnt = 0; busy_cnt = 0;
    push(8'hA5);
    run(FRAME_CYC + 10);
    chk("single_pops", 32'(pop_cnt), 32'd1);
    chk("single_busy_len", 32'(busy_cnt), 32'(FRAME_CYC + 1));

    // Back-to-back 0x00, 0xFF
    pop_cnt = 0; pops.delete();
    push(8'h00);
    push(8'hFF);
    run(2 * FRAME_CYC + 10);
    chk("b2b_pops", 32'(pop_cnt), 32'd2);
    if (pops.size() == 2) chk("b2b_spacing", 32'(pops[1] - pops[0]), 32'(FRAME_CYC));

    // Enable gating
    pop_cnt = 0;
    tx_enable = 1'b0;
    push(WL'($urandom));
    run(20);
    chk("gate_no_pop", 32'(pop_cnt), 32'd0);
    push(WL'($urandom));
    tx_enable = 1'b1;
    run(5);
    tx_enable = 1'b0;
    run(FRAME_CYC + 20);
    chk("gate_one_pop", 32'(pop_cnt), 32'd1);
    chk("gate_fifo_left", 32'(fifo_q.size()), 32'd1);
    fifo_q.delete();
    drive_fifo();

    // Reset during DATA bit 3
    pop_cnt = 0;
    tx_enable = 1'b1;
    push(WL'($urandom));
    for (int i = 0; i < 5 && pop_cnt == 0; i++) cycle();
    chk("rst_popped", 32'(pop_cnt), 32'd1);
    run(CPB + 3 * CPB);
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    chk("rst_tx_next", 32'(tx), 32'd1);
    chk("rst_busy_next", 32'(busy), 32'd0);
    pop_cnt = 0;
    run(20);
    chk("rst_no_retry", 32'(pop_cnt), 32'd0);

    // Randomized stream with random arrival gaps
    pop_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      push(WL'($urandom));
      run(int'($urandom_range(0, 50)));
    end
    run(7 * FRAME_CYC);
    chk("rand_pops", 32'(pop_cnt), 32'd6);

    // Parity pair 0x07 / 0x03 (parity bits 1 and 0 when compiled in)
    pop_cnt = 0; pops.delete();
    push(8'h07);
    push(8'h03);
    run(2 * FRAME_CYC + 10);
    chk("par_pops", 32'(pop_cnt), 32'd2);
    if (pops.size() == 2) chk("par_frame_len", 32'(pops[1] - pops[0]), 32'(FRAME_CYC));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
